// File: rtl/sprite_rom_arbiter.sv
// Round-robin arbiter that shares one sprite ROM read port between the render
// units. One grant per cycle; a tag pipeline tracks each grant through the ROM
// latency so the returned pixel is routed back to the requester that owns it.
module sprite_rom_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 1,
  parameter int ROM_LAT = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_flush,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  output logic [NUM_REQ-1:0]          o_grant,
  output logic                        o_rom_en,
  output logic [ADDR_W-1:0]           o_rom_addr,
  input  logic [DATA_W-1:0]           i_rom_data,
  output logic [NUM_REQ-1:0]          o_rvalid,
  output logic [DATA_W-1:0]           o_rdata,
  output logic [NUM_REQ*DATA_W-1:0]   o_color
);

  localparam int PTR_W = $clog2(NUM_REQ);

  logic [PTR_W-1:0]   r_ptr;
  logic [NUM_REQ-1:0] r_tag [ROM_LAT];

  logic               w_found;
  logic [PTR_W-1:0]   w_win;
  logic [PTR_W-1:0]   w_ptr_nxt;
  logic [NUM_REQ-1:0] w_grant_oh;
  logic [NUM_REQ-1:0] w_tag_out;

  // Winner search: first active request starting at the round-robin pointer.
  always_comb begin
    int unsigned idx;
    idx     = 0;
    w_found = 1'b0;
    w_win   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      idx = 32'(r_ptr) + i;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (!w_found && i_req[idx[PTR_W-1:0]]) begin
        w_found = 1'b1;
        w_win   = idx[PTR_W-1:0];
      end
    end
  end

  // Grant decode and pointer advance with wrap at the last requester.
  always_comb begin
    w_grant_oh = NUM_REQ'(1) << w_win;
    w_ptr_nxt  = (w_win == PTR_W'(NUM_REQ - 1)) ? '0 : w_win + 1'b1;
    w_tag_out  = r_tag[ROM_LAT-1];
  end

  // Grant register, ROM drive and pointer; flush suppresses any new grant.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_grant    <= '0;
      o_rom_en   <= 1'b0;
      o_rom_addr <= '0;
      r_ptr      <= '0;
    end else if (i_flush) begin
      o_grant    <= '0;
      o_rom_en   <= 1'b0;
      r_ptr      <= '0;
    end else if (w_found) begin
      o_grant    <= w_grant_oh;
      o_rom_en   <= 1'b1;
      o_rom_addr <= i_addr[32'(w_win)*ADDR_W +: ADDR_W];
      r_ptr      <= w_ptr_nxt;
    end else begin
      o_grant    <= '0;
      o_rom_en   <= 1'b0;
    end
  end

  // Tag pipeline: delays o_grant by ROM_LAT so it lines up with i_rom_data.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      for (int unsigned i = 0; i < ROM_LAT; i++) r_tag[i] <= '0;
    end else begin
      r_tag[0] <= o_grant;
      for (int unsigned i = 1; i < ROM_LAT; i++) r_tag[i] <= r_tag[i-1];
    end
  end

  // Return stage: register ROM data and steer it to the owning requester.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_rvalid <= '0;
      o_rdata  <= '0;
      o_color  <= '0;
    end else if (i_flush) begin
      o_rvalid <= '0;
    end else begin
      o_rvalid <= w_tag_out;
      if (|w_tag_out) o_rdata <= i_rom_data;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
        if (w_tag_out[k]) o_color[k*DATA_W +: DATA_W] <= i_rom_data;
      end
    end
  end

endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// Bench for sprite_rom_arbiter: two instances (ROM latency 1 and 3) share one
// stimulus stream; a cycle-indexed reference model predicts grants, ROM drive
// and the per-requester returns.
module tb_sprite_rom_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush;
  logic [3:0]  req;
  logic [31:0] addr;

  logic [3:0] g1, g3, rv1, rv3, col1, col3;
  logic       en1, en3, rd1, rd3, d1, d3;
  logic [7:0] ra1, ra3;

  // ROM models: data is the parity of the address, garbage when not enabled
  logic       p1;
  logic [2:0] p3;
  always @(posedge clk) begin
    p1 <= en1 ? ^ra1 : 1'($urandom);
    p3 <= {p3[1:0], (en3 ? ^ra3 : 1'($urandom))};
  end
  assign d1 = p1;
  assign d3 = p3[2];

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(1), .ROM_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_req(req), .i_addr(addr),
    .o_grant(g1), .o_rom_en(en1), .o_rom_addr(ra1), .i_rom_data(d1),
    .o_rvalid(rv1), .o_rdata(rd1), .o_color(col1));

  sprite_rom_arbiter #(.NUM_REQ(4), .ADDR_W(8), .DATA_W(1), .ROM_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .i_flush(flush), .i_req(req), .i_addr(addr),
    .o_grant(g3), .o_rom_en(en3), .o_rom_addr(ra3), .i_rom_data(d3),
    .o_rvalid(rv3), .o_rdata(rd3), .o_color(col3));

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Reference model state
  logic [3:0] m_grant = '0;
  logic [7:0] m_addr  = '0;
  int         m_ptr   = 0;
  bit         m_rst_pend = 1'b0;
  logic [3:0] q1_rv [16];
  logic [3:0] q3_rv [16];
  logic       q1_rd [16];
  logic       q3_rd [16];
  logic [3:0] e_rv1, e_rv3;
  logic [3:0] m_col1 = '0, m_col3 = '0;
  logic       m_rd1 = 1'b0, m_rd3 = 1'b0;

  // Inputs of cycle cyc -> expected grant at cyc+1, returns at cyc+2+LAT.
  task automatic model_cycle();
    int k;
    if (rst || flush) begin
      for (int d = 1; d <= 2; d++) q1_rv[(cyc + d) % 16] = '0;
      for (int d = 1; d <= 4; d++) q3_rv[(cyc + d) % 16] = '0;
    end
    if (rst) begin
      m_grant = '0; m_addr = '0; m_ptr = 0; m_rst_pend = 1'b1;
    end else if (flush) begin
      m_grant = '0; m_ptr = 0;
    end else begin
      k = -1;
      for (int i = 0; i < NR; i++)
        if (k < 0 && req[(m_ptr + i) % NR]) k = (m_ptr + i) % NR;
      if (k >= 0) begin
        m_grant = 4'(1 << k);
        m_addr  = addr[k*AW +: AW];
        m_ptr   = (k + 1) % NR;
        q1_rv[(cyc + 3) % 16] = m_grant;
        q1_rd[(cyc + 3) % 16] = ^m_addr;
        q3_rv[(cyc + 5) % 16] = m_grant;
        q3_rd[(cyc + 5) % 16] = ^m_addr;
      end else begin
        m_grant = '0;
      end
    end
  endtask

  task automatic model_observe();
    if (m_rst_pend) begin
      m_col1 = '0; m_col3 = '0; m_rd1 = 1'b0; m_rd3 = 1'b0; m_rst_pend = 1'b0;
    end
    e_rv1 = q1_rv[cyc % 16]; q1_rv[cyc % 16] = '0;
    e_rv3 = q3_rv[cyc % 16]; q3_rv[cyc % 16] = '0;
    if (e_rv1 != 0) begin
      m_rd1 = q1_rd[cyc % 16];
      for (int k = 0; k < NR; k++) if (e_rv1[k]) m_col1[k] = m_rd1;
    end
    if (e_rv3 != 0) begin
      m_rd3 = q3_rd[cyc % 16];
      for (int k = 0; k < NR; k++) if (e_rv3[k]) m_col3[k] = m_rd3;
    end
  endtask

  // One clock: inputs already set for this cycle; returns sampled at negedge.
  task automatic step();
    model_cycle();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    model_observe();
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; req = 4'b1111; addr = $urandom;
    for (int i = 0; i < 2; i++) begin
      step();
      tests++;
      if ({g1, en1, ra1, rv1, rd1, col1, g3, en3, ra3, rv3, rd3, col3} !== '0) begin
        fails++;
        $display("FAIL reset_outputs: got %h want 0",
                 {g1, en1, ra1, rv1, rd1, col1, g3, en3, ra3, rv3, rd3, col3});
      end
    end
    rst = 1'b0; addr = $urandom;
    step();
    tests++;
    if ({g1, g3, en1, ra1} !== {4'b0001, 4'b0001, 1'b1, addr[7:0]}) begin
      fails++;
      $display("FAIL reset_first_grant: got g1=%b g3=%b en=%b addr=%h want 0001 0001 1 %h",
               g1, g3, en1, ra1, addr[7:0]);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_g;
    req = 4'b0000; flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 8; i++) begin
      req = 4'b1111; addr = $urandom;
      step();
      exp_g = 4'(1 << (i % 4));
      tests++;
      if ({g1, en1, ra1} !== {exp_g, 1'b1, addr[(i%4)*8 +: 8]}) begin
        fails++;
        $display("FAIL round_robin[%0d]: got g=%b en=%b addr=%h want %b 1 %h",
                 i, g1, en1, ra1, exp_g, addr[(i%4)*8 +: 8]);
      end
    end
  endtask

  task automatic test_latency();
    logic [7:0] a;
    logic       exp_d;
    for (int t = 0; t < 2; t++) begin
      a = (t == 0) ? 8'h35 : 8'h37;
      exp_d = (t == 0) ? 1'b0 : 1'b1;
      req = 4'b0000; flush = 1'b1; step(); flush = 1'b0;
      for (int i = 0; i < 6; i++) step();
      addr = $urandom; addr[23:16] = a; req = 4'b0100;
      step();                                   // N+1
      req = 4'b0000;
      tests++;
      if ({g1, ra1} !== {4'b0100, a}) begin
        fails++;
        $display("FAIL lat_grant: got g=%b addr=%h want 0100 %h", g1, ra1, a);
      end
      step();                                   // N+2
      tests++;
      if (rv1 !== 4'b0000) begin
        fails++; $display("FAIL lat1_early: got rvalid=%b want 0000", rv1);
      end
      step();                                   // N+3
      tests++;
      if ({rv1, rd1, col1[2]} !== {4'b0100, exp_d, exp_d}) begin
        fails++;
        $display("FAIL lat1_return: got rv=%b d=%b c=%b want 0100 %b %b", rv1, rd1, col1[2], exp_d, exp_d);
      end
      step();                                   // N+4
      tests++;
      if (rv3 !== 4'b0000) begin
        fails++; $display("FAIL lat3_early: got rvalid=%b want 0000", rv3);
      end
      step();                                   // N+5
      tests++;
      if ({rv3, rd3, col3[2]} !== {4'b0100, exp_d, exp_d}) begin
        fails++;
        $display("FAIL lat3_return: got rv=%b d=%b c=%b want 0100 %b %b", rv3, rd3, col3[2], exp_d, exp_d);
      end
    end
  endtask

  task automatic test_skip_pointer();
    logic [3:0] reqs [3];
    logic [3:0] exps [3];
    reqs = '{4'b0010, 4'b0001, 4'b1001};
    exps = '{4'b0010, 4'b0001, 4'b1000};
    req = 4'b0000; flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 3; i++) begin
      req = reqs[i]; addr = $urandom;
      step();
      tests++;
      if (g1 !== exps[i]) begin
        fails++; $display("FAIL skip_pointer[%0d]: got %b want %b", i, g1, exps[i]);
      end
    end
  endtask

  task automatic test_flush();
    logic [3:0] sc1, sc3;
    req = 4'b1111;
    for (int i = 0; i < 3; i++) begin addr = $urandom; step(); end
    sc1 = col1; sc3 = col3;
    flush = 1'b1; addr = $urandom;
    step();                                     // N+1
    flush = 1'b0;
    tests++;
    if ({g1, en1, rv1, rv3, col1, col3} !== {4'b0000, 1'b0, 4'b0000, 4'b0000, sc1, sc3}) begin
      fails++;
      $display("FAIL flush_cycle: got g=%b en=%b rv1=%b rv3=%b c1=%b c3=%b want 0000 0 0000 0000 %b %b",
               g1, en1, rv1, rv3, col1, col3, sc1, sc3);
    end
    addr = $urandom;
    step();                                     // N+2
    tests++;
    if ({g1, rv1, rv3, col1, col3} !== {4'b0001, 4'b0000, 4'b0000, sc1, sc3}) begin
      fails++;
      $display("FAIL flush_resume: got g=%b rv1=%b rv3=%b c1=%b c3=%b want 0001 0000 0000 %b %b",
               g1, rv1, rv3, col1, col3, sc1, sc3);
    end
    addr = $urandom;
    step();                                     // N+3
    tests++;
    if ({rv1, rv3, col3} !== {4'b0000, 4'b0000, sc3}) begin
      fails++; $display("FAIL flush_drop: got rv1=%b rv3=%b c3=%b want 0000 0000 %b", rv1, rv3, col3, sc3);
    end
    addr = $urandom;
    step();                                     // N+4
    tests++;
    if ({rv1, rv3, col3} !== {4'b0001, 4'b0000, sc3}) begin
      fails++; $display("FAIL flush_first_return: got rv1=%b rv3=%b c3=%b want 0001 0000 %b", rv1, rv3, col3, sc3);
    end
  endtask

  task automatic test_hold();
    req = 4'b0000; flush = 1'b1; step(); flush = 1'b0;
    for (int i = 0; i < 6; i++) step();
    addr = $urandom; addr[7:0] = 8'h01; req = 4'b0001;
    step();
    req = 4'b1110;
    for (int i = 0; i < 6; i++) begin addr = $urandom; step(); end
    for (int i = 0; i < 20; i++) begin
      addr = $urandom;
      step();
      tests++;
      if ({col1[0], col3[0], rv1[0], rv3[0]} !== 4'b1100) begin
        fails++;
        $display("FAIL hold[%0d]: got c1=%b c3=%b rv1=%b rv3=%b want 1 1 0 0",
                 i, col1[0], col3[0], rv1[0], rv3[0]);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 10000; i++) begin
      rst   = ($urandom % 500) == 0;
      flush = ($urandom % 64) == 0;
      req   = 4'($urandom);
      if ($urandom % 8 == 0) req = 4'(1 << ($urandom % 4));
      addr  = $urandom;
      step();
      tests++;
      if ({g1, en1, ra1, g3, en3, ra3} !== {m_grant, |m_grant, m_addr, m_grant, |m_grant, m_addr}) begin
        fails++;
        $display("FAIL rand_ctl @%0d: got %b %b %h / %b %b %h want %b %b %h",
                 cyc, g1, en1, ra1, g3, en3, ra3, m_grant, |m_grant, m_addr);
      end
      tests++;
      if ({rv1, col1} !== {e_rv1, m_col1}) begin
        fails++;
        $display("FAIL rand_ret1 @%0d: got rv=%b col=%b want %b %b", cyc, rv1, col1, e_rv1, m_col1);
      end
      tests++;
      if ({rv3, col3} !== {e_rv3, m_col3}) begin
        fails++;
        $display("FAIL rand_ret3 @%0d: got rv=%b col=%b want %b %b", cyc, rv3, col3, e_rv3, m_col3);
      end
      if (e_rv1 != 0) begin
        tests++;
        if (rd1 !== m_rd1) begin
          fails++; $display("FAIL rand_data1 @%0d: got %b want %b", cyc, rd1, m_rd1);
        end
      end
      if (e_rv3 != 0) begin
        tests++;
        if (rd3 !== m_rd3) begin
          fails++; $display("FAIL rand_data3 @%0d: got %b want %b", cyc, rd3, m_rd3);
        end
      end
    end
    rst = 1'b0; flush = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      q1_rv[i] = '0; q3_rv[i] = '0; q1_rd[i] = 1'b0; q3_rd[i] = 1'b0;
    end
    rst = 1'b1; flush = 1'b0; req = '0; addr = '0;
    @(negedge clk);
    test_reset();
    test_round_robin();
    test_latency();
    test_skip_pointer();
    test_flush();
    test_hold();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
